gcd_result_checker: RTL and testbench

Sequential checker for the GCD datapath. It takes an operand pair P, Q and a claimed result R, all 8-bit sign-magnitude, and decides whether R is exactly gcd(|P|,|Q|).
- Method: restoring division of each magnitude by R, then a binary (Stein) coprimality test on the two quotients.
- Placement: sits downstream of the GCD unit as the consuming/verifying end, and is also used as a self-check monitor in system benches.

---
 rtl/gcd_result_checker_if.sv | 16 +
 rtl/gcd_result_checker.sv | 187 ++++++++++++++++++
 tb/tb_gcd_result_checker.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/gcd_result_checker_if.sv
// Request/verdict bundle between a GCD producer (master) and gcd_result_checker (slave).
interface gcd_result_checker_if #(
  parameter int unsigned W = 8
);
  logic         start;
  logic [W-1:0] P;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         busy;
  logic         done;
  logic         pass;
  logic [1:0]   code;

  modport master (output start, P, Q, R, input busy, done, pass, code);
  modport slave  (input start, P, Q, R, output busy, done, pass, code);
endinterface

// File: rtl/gcd_result_checker.sv
// Verifies a claimed GCD R of sign-magnitude operands P, Q: divide both magnitudes
// by R (restoring division), then check the two quotients are coprime (binary GCD).
module gcd_result_checker #(
  parameter int unsigned W = 8
) (
  input  logic               clk,
  input  logic               rst,
  gcd_result_checker_if.slave bus
);

  localparam int unsigned MW = W - 1;
  localparam int unsigned CW = $clog2(W);

  localparam logic [1:0] CODE_PASS = 2'd0;
  localparam logic [1:0] CODE_SIGN = 2'd1;
  localparam logic [1:0] CODE_NDIV = 2'd2;
  localparam logic [1:0] CODE_NGCD = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DIVP,
    S_DIVQ,
    S_COPR,
    S_DONE
  } state_t;

  state_t        state;
  logic [MW-1:0] p_r, q_r, r_r;
  logic          rneg_r;
  logic [MW-1:0] dvd_r;
  logic [MW-1:0] rem_r;
  logic [CW-1:0] cnt_r;
  logic [MW-1:0] a_r, b_r;
  logic          first_r;
  logic          v_pass;
  logic [1:0]    v_code;
  logic          busy_r, done_r, pass_r, code_unused_guard;
  logic [1:0]    code_r;

  // Operand signs carry no meaning for a GCD; only magnitudes are latched.
  logic unused_signs;
  assign unused_signs = bus.P[W-1] ^ bus.Q[W-1];
  assign code_unused_guard = 1'b0;

  // One restoring-division step; quotient bits shift into the dividend register.
  logic [MW:0]   trial, rem_nxt;
  logic          ge;
  logic [MW-1:0] dvd_nxt;
  logic          last_step;

  assign trial     = {rem_r, dvd_r[MW-1]};
  assign ge        = (trial >= {1'b0, r_r});
  assign rem_nxt   = ge ? (trial - {1'b0, r_r}) : trial;
  assign dvd_nxt   = {dvd_r[MW-2:0], ge};
  assign last_step = (cnt_r == CW'(MW - 1));

  logic          pq_zero;
  logic          res_valid;
  logic [MW-1:0] res_val;

  assign pq_zero   = (p_r == '0) && (q_r == '0);
  assign res_valid = (a_r == '0) || (b_r == '0);
  assign res_val   = (a_r == '0) ? b_r : a_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      p_r     <= '0;
      q_r     <= '0;
      r_r     <= '0;
      rneg_r  <= 1'b0;
      dvd_r   <= '0;
      rem_r   <= '0;
      cnt_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      first_r <= 1'b0;
      v_pass  <= 1'b0;
      v_code  <= CODE_PASS;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      code_r  <= CODE_PASS;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            p_r    <= bus.P[MW-1:0];
            q_r    <= bus.Q[MW-1:0];
            r_r    <= bus.R[MW-1:0];
            rneg_r <= bus.R[W-1];
            v_pass <= 1'b0;
            v_code <= CODE_PASS;
            pass_r <= 1'b0;
            code_r <= CODE_PASS;
            busy_r <= 1'b1;
            state  <= S_CHECK;
          end
        end

        S_CHECK: begin
          dvd_r <= p_r;
          rem_r <= '0;
          cnt_r <= '0;
          state <= S_DIVP;
          if (rneg_r) begin
            v_code <= CODE_SIGN;
            state  <= S_DONE;
          end else if (r_r == '0) begin
            // gcd(0,0)=0 is the only case a zero claim is right.
            v_pass <= pq_zero;
            v_code <= pq_zero ? CODE_PASS : CODE_SIGN;
            state  <= S_DONE;
          end else if (pq_zero) begin
            v_code <= CODE_SIGN;
            state  <= S_DONE;
          end
        end

        S_DIVP, S_DIVQ: begin
          dvd_r <= dvd_nxt;
          rem_r <= rem_nxt[MW-1:0];
          cnt_r <= cnt_r + CW'(1);
          if (last_step) begin
            cnt_r <= '0;
            rem_r <= '0;
            if (rem_nxt != '0) begin
              v_code <= CODE_NDIV;
              state  <= S_DONE;
            end else if (state == S_DIVP) begin
              a_r   <= dvd_nxt;
              dvd_r <= q_r;
              state <= S_DIVQ;
            end else begin
              b_r     <= dvd_nxt;
              first_r <= 1'b1;
              state   <= S_COPR;
            end
          end
        end

        S_COPR: begin
          first_r <= 1'b0;
          // A common factor of 2 in both quotients means R was too small.
          if (first_r && !a_r[0] && !b_r[0]) begin
            v_code <= CODE_NGCD;
            state  <= S_DONE;
          end else if (res_valid) begin
            if (res_val == MW'(1)) begin
              v_pass <= 1'b1;
              v_code <= CODE_PASS;
            end else begin
              v_code <= CODE_NGCD;
            end
            state <= S_DONE;
          end else if (!a_r[0]) begin
            a_r <= a_r >> 1;
          end else if (!b_r[0]) begin
            b_r <= b_r >> 1;
          end else if (a_r > b_r) begin
            a_r <= a_r - b_r;
          end else begin
            b_r <= b_r - a_r;
          end
        end

        S_DONE: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
          pass_r <= v_pass;
          code_r <= v_code;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r | code_unused_guard;
  assign bus.done = done_r;
  assign bus.pass = pass_r;
  assign bus.code = code_r;

endmodule

// File: tb/tb_gcd_result_checker.sv
// Self-checking bench for gcd_result_checker: vector table, directed corner sequences, strided sweep.
module tb_gcd_result_checker;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  gcd_result_checker_if #(.W(8)) bus ();

  gcd_result_checker #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int errors   = 0;
  int runs     = 0;
  int done_cnt = 0;
  logic [2:0] sb[$];

  typedef struct {
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] r;
    logic       ep;
    logic [1:0] ec;
    int         lat;
  } vec_t;

  vec_t vecs[13];

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int gcd(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Issue one request, push its expectation, wait (bounded) for done, then score it.
  // inj_at > 0 pulses a second start (1,1,1) that many cycles after acceptance.
  task automatic run(input string tag, input logic [7:0] p, input logic [7:0] q, input logic [7:0] r,
                     input logic ep, input logic [1:0] ec, input int bound, input int inj_at,
                     output int lat);
    logic       got;
    logic       busy_ok;
    logic [2:0] e;
    @(negedge clk);
    bus.P = p; bus.Q = q; bus.R = r; bus.start = 1'b1;
    sb.push_back({ep, ec});
    runs++;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0; got = 1'b0; busy_ok = 1'b1;
    while (!got && lat < bound) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done === 1'b1) got = 1'b1;
      else if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (inj_at != 0 && lat == inj_at) begin
        bus.P = 8'd1; bus.Q = 8'd1; bus.R = 8'd1; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check_val({tag, ".done_seen"}, got, 1);
    check_val({tag, ".busy_during"}, busy_ok, 1);
    e = sb.pop_front();
    if (got) begin
      check_val({tag, ".pass"}, bus.pass, e[2]);
      check_val({tag, ".code"}, bus.code, e[1:0]);
      check_val({tag, ".busy_at_done"}, bus.busy, 0);
    end
  endtask

  initial begin
    int lat;
    int dc;
    int g;
    logic [7:0] p8, q8;

    vecs[0]  = '{8'd12,  8'd18,  8'd6,   1'b1, 2'd0, 21};
    vecs[1]  = '{8'd12,  8'd18,  8'd3,   1'b0, 2'd3, 17};
    vecs[2]  = '{8'd12,  8'd18,  8'd5,   1'b0, 2'd2, 9};
    vecs[3]  = '{8'h8C,  8'h12,  8'd6,   1'b1, 2'd0, 21};
    vecs[4]  = '{8'd0,   8'd0,   8'd0,   1'b1, 2'd0, 2};
    vecs[5]  = '{8'd0,   8'd9,   8'd9,   1'b1, 2'd0, 17};
    vecs[6]  = '{8'd0,   8'd9,   8'd3,   1'b0, 2'd3, 17};
    vecs[7]  = '{8'd7,   8'd0,   8'd0,   1'b0, 2'd1, 2};
    vecs[8]  = '{8'd12,  8'd18,  8'h86,  1'b0, 2'd1, 2};
    vecs[9]  = '{8'h80,  8'd0,   8'd0,   1'b1, 2'd0, 2};
    vecs[10] = '{8'd0,   8'd0,   8'h80,  1'b0, 2'd1, 2};
    vecs[11] = '{8'h7F,  8'h7F,  8'h7F,  1'b1, 2'd0, 18};
    vecs[12] = '{8'h7F,  8'h81,  8'd1,   1'b1, 2'd0, 30};

    rst = 1'b1; bus.start = 1'b0; bus.P = '0; bus.Q = '0; bus.R = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset.busy", bus.busy, 0);
    check_val("reset.done", bus.done, 0);
    check_val("reset.pass", bus.pass, 0);
    check_val("reset.code", bus.code, 0);
    @(negedge clk) rst = 1'b0;

    foreach (vecs[i]) begin
      run($sformatf("vec%0d", i), vecs[i].p, vecs[i].q, vecs[i].r, vecs[i].ep, vecs[i].ec, 32, 0, lat);
      check_val($sformatf("vec%0d.latency", i), lat, vecs[i].lat);
    end

    // Second start during DIVQ must not disturb the running check.
    run("ignore_start", 8'd96, 8'd64, 8'd32, 1'b1, 2'd0, 32, 10, lat);
    check_val("ignore_start.latency", lat, 21);

    // Abort in COPR: reset clears everything and no done appears for that run.
    @(negedge clk);
    bus.P = 8'd35; bus.Q = 8'd21; bus.R = 8'd7; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (16) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("abort.busy", bus.busy, 0);
    check_val("abort.done", bus.done, 0);
    check_val("abort.pass", bus.pass, 0);
    check_val("abort.code", bus.code, 0);
    rst = 1'b0;
    dc = done_cnt;
    repeat (40) @(posedge clk);
    check_val("abort.no_done", done_cnt, dc);
    run("after_abort", 8'd35, 8'd21, 8'd7, 1'b1, 2'd0, 32, 0, lat);
    check_val("after_abort.latency", lat, 22);

    // Strided sweep over 7-bit magnitudes with random operand signs.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 20; j++) begin
        int p;
        int q;
        p = (i == 15) ? 127 : i * 9;
        q = (j == 19) ? 127 : j * 7;
        g = gcd(p, q);
        p8 = {1'($urandom), 7'(p)};
        q8 = {1'($urandom), 7'(q)};
        run($sformatf("sweep_%0d_%0d", p, q), p8, q8, 8'(g), 1'b1, 2'd0, 64, 0, lat);
        if (g + 1 <= 127)
          run($sformatf("sweep_%0d_%0d_r+1", p, q), p8, q8, 8'(g + 1), 1'b0,
              (p == 0 && q == 0) ? 2'd1 : 2'd2, 64, 0, lat);
      end
    end

    repeat (5) @(posedge clk);
    check_val("done_pulse_count", done_cnt, runs);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
